// File: rtl/csi_rx_lane_delay_cal.sv
// Per-lane IDELAY tap sweep: scores every tap by HS sync-word hits, finds the widest
// passing eye on each lane and loads its centre tap back into the lane PHY.
module csi_rx_lane_delay_cal #(
    parameter int         NUM_LANES     = 2,
    parameter int         TAP_BITS      = 5,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         DWELL_CYCLES  = 256,
    parameter int         MIN_HITS      = 4,
    parameter logic [7:0] SYNC_WORD     = 8'hB8,
    parameter int         MIN_EYE       = 4,
    parameter int         DEFAULT_TAP   = 0
) (
    input  logic                               byte_clock,
    input  logic                               reset,
    input  logic                               cal_start,
    input  logic [NUM_LANES*8-1:0]             deser_in,
    output logic [NUM_LANES-1:0]               load,
    output logic [NUM_LANES*TAP_BITS-1:0]      delay_in,
    output logic                               cal_busy,
    output logic                               cal_done,
    output logic [NUM_LANES-1:0]               lane_locked,
    output logic [NUM_LANES*(TAP_BITS+1)-1:0]  eye_width
);

    localparam int HIT_W   = $clog2(DWELL_CYCLES + 1);
    localparam int CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TAP_BITS-1:0] TAP_MAX_L   = '1;
    localparam logic [TAP_BITS-1:0] DEF_TAP     = TAP_BITS'(DEFAULT_TAP);
    localparam logic [TAP_BITS:0]   MIN_EYE_L   = (TAP_BITS+1)'(MIN_EYE);
    localparam logic [TAP_BITS:0]   RL_ONE      = (TAP_BITS+1)'(1);
    localparam logic [HIT_W-1:0]    MIN_HITS_L  = HIT_W'(MIN_HITS);
    localparam logic [HIT_W-1:0]    HIT_ONE     = HIT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_DWELL, S_EVAL, S_APPLY, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [TAP_BITS-1:0]   tap_q, tap_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_LANES-1:0]  locked_q, locked_d;

    logic [7:0]            prev_q       [NUM_LANES];
    logic [7:0]            prev_d       [NUM_LANES];
    logic [HIT_W-1:0]      hits_q       [NUM_LANES];
    logic [HIT_W-1:0]      hits_d       [NUM_LANES];
    logic [TAP_BITS:0]     run_len_q    [NUM_LANES];
    logic [TAP_BITS:0]     run_len_d    [NUM_LANES];
    logic [TAP_BITS-1:0]   run_start_q  [NUM_LANES];
    logic [TAP_BITS-1:0]   run_start_d  [NUM_LANES];
    logic [TAP_BITS:0]     best_len_q   [NUM_LANES];
    logic [TAP_BITS:0]     best_len_d   [NUM_LANES];
    logic [TAP_BITS-1:0]   best_start_q [NUM_LANES];
    logic [TAP_BITS-1:0]   best_start_d [NUM_LANES];
    logic [TAP_BITS-1:0]   delay_q      [NUM_LANES];
    logic [TAP_BITS-1:0]   delay_d      [NUM_LANES];
    logic [TAP_BITS:0]     eye_q        [NUM_LANES];
    logic [TAP_BITS:0]     eye_d        [NUM_LANES];

    logic                  lane_pass    [NUM_LANES];
    logic                  run_close    [NUM_LANES];
    logic [TAP_BITS:0]     run_len_n    [NUM_LANES];
    logic [TAP_BITS-1:0]   run_start_n  [NUM_LANES];
    logic [TAP_BITS-1:0]   apply_tap    [NUM_LANES];

    // The sync word may straddle the byte boundary, so search every bit offset of {cur,prev}.
    function automatic logic sync_hit(input logic [7:0] cur, input logic [7:0] prev);
        logic [15:0] w;
        w = {cur, prev};
        sync_hit = 1'b0;
        for (int o = 0; o < 8; o++) begin
            if (w[o +: 8] == SYNC_WORD) sync_hit = 1'b1;
        end
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_pass[i]   = (hits_q[i] >= MIN_HITS_L);
            run_start_n[i] = (lane_pass[i] && run_len_q[i] == '0) ? tap_q : run_start_q[i];
            run_len_n[i]   = lane_pass[i] ? run_len_q[i] + RL_ONE : run_len_q[i];
            run_close[i]   = !lane_pass[i] || (tap_q == TAP_MAX_L);
            apply_tap[i]   = (best_len_q[i] >= MIN_EYE_L)
                           ? best_start_q[i] + TAP_BITS'(best_len_q[i] >> 1) : DEF_TAP;
        end
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            prev_d[i]       = deser_in[8*i +: 8];
            hits_d[i]       = hits_q[i];
            run_len_d[i]    = run_len_q[i];
            run_start_d[i]  = run_start_q[i];
            best_len_d[i]   = best_len_q[i];
            best_start_d[i] = best_start_q[i];
            delay_d[i]      = delay_q[i];
            eye_d[i]        = eye_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (cal_start) begin
                    tap_d    = '0;
                    cnt_d    = '0;
                    locked_d = '0;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        run_len_d[i]    = '0;
                        run_start_d[i]  = '0;
                        best_len_d[i]   = '0;
                        best_start_d[i] = '0;
                        eye_d[i]        = '0;
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d = '0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    delay_d[i] = tap_q;
                    hits_d[i]  = '0;
                end
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DWELL: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (sync_hit(deser_in[8*i +: 8], prev_q[i]) && hits_q[i] != '1)
                        hits_d[i] = hits_q[i] + HIT_ONE;
                end
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_EVAL: begin
                // Strict compare on close keeps the earliest of equally wide eyes.
                for (int i = 0; i < NUM_LANES; i++) begin
                    run_start_d[i] = run_start_n[i];
                    run_len_d[i]   = lane_pass[i] ? run_len_n[i] : '0;
                    if (run_close[i] && run_len_n[i] > best_len_q[i]) begin
                        best_start_d[i] = run_start_n[i];
                        best_len_d[i]   = run_len_n[i];
                    end
                end
                if (tap_q == TAP_MAX_L) begin
                    state_d = S_APPLY;
                end else begin
                    tap_d   = tap_q + TAP_BITS'(1);
                    state_d = S_LOAD;
                end
            end
            S_APPLY: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    delay_d[i]  = apply_tap[i];
                    locked_d[i] = (best_len_q[i] >= MIN_EYE_L);
                    eye_d[i]    = best_len_q[i];
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            cnt_q    <= '0;
            locked_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                prev_q[i]       <= '0;
                hits_q[i]       <= '0;
                run_len_q[i]    <= '0;
                run_start_q[i]  <= '0;
                best_len_q[i]   <= '0;
                best_start_q[i] <= '0;
                delay_q[i]      <= DEF_TAP;
                eye_q[i]        <= '0;
            end
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                prev_q[i]       <= prev_d[i];
                hits_q[i]       <= hits_d[i];
                run_len_q[i]    <= run_len_d[i];
                run_start_q[i]  <= run_start_d[i];
                best_len_q[i]   <= best_len_d[i];
                best_start_q[i] <= best_start_d[i];
                delay_q[i]      <= delay_d[i];
                eye_q[i]        <= eye_d[i];
            end
        end
    end

    assign cal_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cal_done    = (state_q == S_DONE);
    assign lane_locked = locked_q;

    always_comb begin
        load      = '0;
        delay_in  = '0;
        eye_width = '0;
        if (state_q == S_LOAD || state_q == S_APPLY) load = '1;
        for (int i = 0; i < NUM_LANES; i++) begin
            case (state_q)
                S_LOAD:  delay_in[TAP_BITS*i +: TAP_BITS] = tap_q;
                S_APPLY: delay_in[TAP_BITS*i +: TAP_BITS] = apply_tap[i];
                default: delay_in[TAP_BITS*i +: TAP_BITS] = delay_q[i];
            endcase
            eye_width[(TAP_BITS+1)*i +: (TAP_BITS+1)] = eye_q[i];
        end
    end

endmodule

// File: tb/tb_csi_rx_lane_delay_cal.sv
// Bench for csi_rx_lane_delay_cal: a two-lane PHY model returns sync patterns on chosen taps
// and a scoreboard of expected calibration results is checked at each cal_done.
module tb_csi_rx_lane_delay_cal;

    localparam int SWEEP_LEN = 32 * (1 + 8 + 256 + 1) + 2;

    logic        byte_clock;
    logic        reset;
    logic        cal_start;
    logic [15:0] deser_in;
    logic [1:0]  load;
    logic [9:0]  delay_in;
    logic        cal_busy;
    logic        cal_done;
    logic [1:0]  lane_locked;
    logic [11:0] eye_width;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      name;
        logic [9:0] delay;
        logic [11:0] eye;
        logic [1:0] locked;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] pass_mask [2];
    int          burst_len;
    logic [4:0]  lane_tap  [2];
    int          since_load[2];

    csi_rx_lane_delay_cal dut (
        .byte_clock (byte_clock),
        .reset      (reset),
        .cal_start  (cal_start),
        .deser_in   (deser_in),
        .load       (load),
        .delay_in   (delay_in),
        .cal_busy   (cal_busy),
        .cal_done   (cal_done),
        .lane_locked(lane_locked),
        .eye_width  (eye_width)
    );

    initial byte_clock = 1'b0;
    always #5 byte_clock = ~byte_clock;

    // Passing taps carry either 0xC0/0x05 pairs (sync word at bit offset 3) or a short
    // burst of 0xB8 bytes giving exactly burst_len hits; failing taps carry zeros.
    function automatic logic [7:0] model_byte(input int lane);
        if (!pass_mask[lane][lane_tap[lane]]) return 8'h00;
        if (burst_len == 0) return (since_load[lane] % 2 == 0) ? 8'hC0 : 8'h05;
        if (since_load[lane] >= 100 && since_load[lane] < 100 + burst_len) return 8'hB8;
        return 8'h00;
    endfunction

    initial begin
        deser_in = '0;
        for (int i = 0; i < 2; i++) begin
            lane_tap[i]   = '0;
            since_load[i] = 0;
        end
        forever begin
            @(negedge byte_clock);
            for (int i = 0; i < 2; i++) begin
                if (load[i] === 1'b1) begin
                    lane_tap[i]   = delay_in[5*i +: 5];
                    since_load[i] = 0;
                end else begin
                    since_load[i] = since_load[i] + 1;
                end
                deser_in[8*i +: 8] = model_byte(i);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] m0, input logic [31:0] m1,
                                 input int burst, input logic [4:0] d0, input logic [4:0] d1,
                                 input logic [5:0] e0, input logic [5:0] e1, input logic [1:0] lk,
                                 input int inject_at);
        exp_t e;
        int   cycles;
        int   loads;
        bit   seen;
        pass_mask[0] = m0;
        pass_mask[1] = m1;
        burst_len    = burst;
        e.name   = name;
        e.delay  = {d1, d0};
        e.eye    = {e1, e0};
        e.locked = lk;
        sb_q.push_back(e);

        @(negedge byte_clock);
        cal_start = 1'b1;
        @(negedge byte_clock);
        cal_start = 1'b0;
        checkOutput({name, " busy after start"}, 32'(cal_busy), 32'd1);

        cycles = 0;
        loads  = 0;
        seen   = 1'b0;
        while (!seen && cycles < 9000) begin
            if (load == 2'b11) begin
                if (loads < 32)
                    checkOutput({name, " sweep tap"}, 32'(delay_in), 32'({loads[4:0], loads[4:0]}));
                else
                    checkOutput({name, " apply value"}, 32'(delay_in), 32'(sb_q[0].delay));
                loads++;
            end
            if (cal_done) begin
                seen = 1'b1;
            end else begin
                cal_start = (cycles == inject_at);
                cycles++;
                @(negedge byte_clock);
            end
        end
        cal_start = 1'b0;

        checkOutput({name, " done seen"}, 32'(seen), 32'd1);
        e = sb_q.pop_front();
        checkOutput({e.name, " sweep length"}, 32'(cycles + 1), 32'(SWEEP_LEN));
        checkOutput({e.name, " load count"}, 32'(loads), 32'd33);
        checkOutput({e.name, " busy at done"}, 32'(cal_busy), 32'd0);
        checkOutput({e.name, " delay_in"}, 32'(delay_in), 32'(e.delay));
        checkOutput({e.name, " eye_width"}, 32'(eye_width), 32'(e.eye));
        checkOutput({e.name, " lane_locked"}, 32'(lane_locked), 32'(e.locked));

        @(negedge byte_clock);
        checkOutput({e.name, " done one cycle"}, 32'(cal_done), 32'd0);
        checkOutput({e.name, " idle load"}, 32'(load), 32'd0);
        checkOutput({e.name, " delay held"}, 32'(delay_in), 32'(e.delay));
        checkOutput({e.name, " locked held"}, 32'(lane_locked), 32'(e.locked));
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        cal_start    = 1'b0;
        pass_mask[0] = '0;
        pass_mask[1] = '0;
        burst_len    = 0;

        repeat (3) @(negedge byte_clock);
        reset = 1'b0;
        repeat (10) @(negedge byte_clock);
        checkOutput("reset load", 32'(load), 32'd0);
        checkOutput("reset delay_in", 32'(delay_in), 32'd0);
        checkOutput("reset busy", 32'(cal_busy), 32'd0);
        checkOutput("reset done", 32'(cal_done), 32'd0);
        checkOutput("reset locked", 32'(lane_locked), 32'd0);
        checkOutput("reset eye", 32'(eye_width), 32'd0);

        applyStimulus("basic eye", 32'h001FFC00, 32'hFFFFFFFF, 0, 5'd15, 5'd16, 6'd11, 6'd32, 2'b11, -1);
        applyStimulus("two runs", 32'h03FFF078, 32'h00000000, 0, 5'd19, 5'd0, 6'd14, 6'd0, 2'b01, -1);
        applyStimulus("tie earliest", 32'h0000F078, 32'h00000007, 0, 5'd5, 5'd0, 6'd4, 6'd3, 2'b01, -1);
        applyStimulus("run at tap max", 32'hF0000000, 32'hF000000F, 0, 5'd30, 5'd2, 6'd4, 6'd4, 2'b11, -1);
        applyStimulus("no hits", 32'h00000000, 32'h00000000, 0, 5'd0, 5'd0, 6'd0, 6'd0, 2'b00, -1);
        applyStimulus("three hits", 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 5'd0, 5'd0, 6'd0, 6'd0, 2'b00, -1);
        applyStimulus("four hits", 32'hFFFFFFFF, 32'h000003E0, 4, 5'd16, 5'd7, 6'd32, 6'd5, 2'b11, -1);

        pass_mask[0] = 32'h001FFC00;
        pass_mask[1] = 32'hFFFFFFFF;
        burst_len    = 0;
        @(negedge byte_clock);
        cal_start = 1'b1;
        @(negedge byte_clock);
        cal_start = 1'b0;
        n = 0;
        while (!(load == 2'b11 && delay_in == 10'h0E7) && n < 3000) begin
            @(negedge byte_clock);
            n++;
        end
        checkOutput("reached tap 7", 32'(load == 2'b11 && delay_in == 10'h0E7), 32'd1);
        repeat (30) @(negedge byte_clock);
        checkOutput("busy in dwell", 32'(cal_busy), 32'd1);
        reset = 1'b1;
        @(negedge byte_clock);
        checkOutput("mid reset busy", 32'(cal_busy), 32'd0);
        checkOutput("mid reset load", 32'(load), 32'd0);
        checkOutput("mid reset delay_in", 32'(delay_in), 32'd0);
        checkOutput("mid reset done", 32'(cal_done), 32'd0);
        reset = 1'b0;
        @(negedge byte_clock);
        checkOutput("after reset load", 32'(load), 32'd0);

        applyStimulus("restart", 32'h001FFC00, 32'hFFFFFFFF, 0, 5'd15, 5'd16, 6'd11, 6'd32, 2'b11, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
